// File: rtl/next_prime_gen.sv
// Iterative next/previous prime search by trial division with a bit-serial remainder.
// Optional CYCLE_COUNT_EN adds a saturating start-to-done cycle count output.
module next_prime_gen #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q_out,
  output logic             none
`ifdef CYCLE_COUNT_EN
  ,
  output logic [15:0]      cycles
`endif
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MAXV = '1;

  typedef enum logic [2:0] {IDLE, TEST, DIV, STEP, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic             none_q, none_d;

  logic             accept;
  logic             fin;
  logic             found;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH:0]   d_inc;
  logic [2*WIDTH+1:0] dsq;

  assign accept = start & ~busy_q;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shl   = {rem_q, cand_q[bit_q]};
    rem_n = (shl >= {1'b0, d_q}) ? WIDTH'(shl - {1'b0, d_q})
                                 : WIDTH'(shl);
    d_inc = {1'b0, d_q} + (WIDTH+1)'(2);
    dsq   = {{(WIDTH+1){1'b0}}, d_inc} * {{(WIDTH+1){1'b0}}, d_inc};
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    dir_d   = dir_q;
    d_d     = d_q;
    rem_d   = rem_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    qout_d  = qout_q;
    none_d  = none_q;
    fin     = 1'b0;
    found   = 1'b0;
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          cand_d  = q_in;
          dir_d   = dir;
          busy_d  = 1'b1;
          state_d = TEST;
        end
      end
      TEST: begin
        if (cand_q < WIDTH'(2)) begin
          state_d = STEP;
        end else if (cand_q == WIDTH'(2) || cand_q == WIDTH'(3)) begin
          fin   = 1'b1;
          found = 1'b1;
        end else if (!cand_q[0]) begin
          state_d = STEP;
        end else begin
          d_d     = WIDTH'(3);
          rem_d   = '0;
          bit_d   = BW'(WIDTH-1);
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d = rem_n;
        bit_d = bit_q - BW'(1);
        if (bit_q == '0) begin
          if (rem_n == '0) begin
            state_d = STEP;
          end else if (dsq > {{(WIDTH+2){1'b0}}, cand_q}) begin
            fin   = 1'b1;
            found = 1'b1;
          end else begin
            d_d   = d_inc[WIDTH-1:0];
            rem_d = '0;
            bit_d = BW'(WIDTH-1);
          end
        end
      end
      STEP: begin
        if (!dir_q) begin
          if (cand_q == MAXV) begin
            fin = 1'b1;
          end else begin
            cand_d  = cand_q + WIDTH'(1);
            state_d = TEST;
          end
        end else begin
          if (cand_q <= WIDTH'(2)) begin
            fin = 1'b1;
          end else begin
            cand_d  = cand_q - WIDTH'(1);
            state_d = TEST;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d = FIN;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      qout_d  = found ? cand_q : '0;
      none_d  = ~found;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= '0;
      dir_q   <= 1'b0;
      d_q     <= '0;
      rem_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      qout_q  <= '0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      dir_q   <= dir_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      qout_q  <= qout_d;
      none_q  <= none_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign q_out = qout_q;
  assign none  = none_q;

`ifdef CYCLE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] cnt_inc;

  // cnt_q already includes the accepting cycle, so +1 covers the done cycle.
  always_comb begin
    cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    if (accept) begin
      cnt_d = 16'd2;
    end else if (busy_q) begin
      cnt_d = cnt_inc;
    end
    if (fin) begin
      cyc_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      cyc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
    end
  end

  assign cycles = cyc_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_next_prime_gen.sv
// Self-checking bench for next_prime_gen at WIDTH=7 and WIDTH=4.
// A trial-division reference model predicts every result; literals pin it.
module tb_next_prime_gen;

  typedef struct {
    int q;
    int n;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       dir;
  logic       start7, start4;
  logic [6:0] q7, q_out7;
  logic [3:0] q4, q_out4;
  logic       busy7, done7, none7;
  logic       busy4, done4, none4;
`ifdef CYCLE_COUNT_EN
  logic [15:0] cyc7, cyc4;
`endif

  int ncmp = 0;
  int nerr = 0;
  exp_t e7[$];
  exp_t e4[$];

  next_prime_gen #(.WIDTH(7)) u7 (
    .clk(clk), .rst(rst), .start(start7), .dir(dir), .q_in(q7),
    .busy(busy7), .done(done7), .q_out(q_out7), .none(none7)
`ifdef CYCLE_COUNT_EN
    , .cycles(cyc7)
`endif
  );

  next_prime_gen #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .dir(dir), .q_in(q4),
    .busy(busy4), .done(done4), .q_out(q_out4), .none(none4)
`ifdef CYCLE_COUNT_EN
    , .cycles(cyc4)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit is_prime(input int c);
    if (c < 2) return 1'b0;
    for (int k = 2; k * k <= c; k++)
      if (c % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t ref_model(input int w, input int q, input bit dn);
    exp_t r;
    int top;
    top = (1 << w) - 1;
    r.q = 0;
    r.n = 1;
    if (!dn) begin
      for (int c = q; c <= top; c++)
        if (is_prime(c)) begin r.q = c; r.n = 0; break; end
    end else begin
      for (int c = q; c >= 0; c--)
        if (is_prime(c)) begin r.q = c; r.n = 0; break; end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done7) begin
      if (e7.size() == 0) begin
        ncmp++; nerr++;
        $display("FAIL spurious_done7: got done=1, expected 0");
      end else begin
        e = e7.pop_front();
        chk("q_out7", int'(q_out7), e.q);
        chk("none7", int'(none7), e.n);
        chk("busy7_at_done", int'(busy7), 0);
      end
    end
    if (!rst && done4) begin
      if (e4.size() == 0) begin
        ncmp++; nerr++;
        $display("FAIL spurious_done4: got done=1, expected 0");
      end else begin
        e = e4.pop_front();
        chk("q_out4", int'(q_out4), e.q);
        chk("none4", int'(none4), e.n);
        chk("busy4_at_done", int'(busy4), 0);
      end
    end
  end

  // Issue a start while the DUT is idle; returns one cycle after acceptance.
  task automatic go(input int w, input int q, input bit dn);
    exp_t e;
    e = ref_model(w, q, dn);
    dir = dn;
    if (w == 7) begin
      q7 = 7'(q); start7 = 1'b1; e7.push_back(e);
    end else begin
      q4 = 4'(q); start4 = 1'b1; e4.push_back(e);
    end
    @(posedge clk); #1;
    start7 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic wait_done(input int w, input int n0,
                           output int lat, output int rq, output int rn);
    int n;
    bit d;
    n = n0;
    d = (w == 7) ? done7 : done4;
    while (!d && n < 5000) begin
      @(posedge clk); #1;
      n++;
      d = (w == 7) ? done7 : done4;
    end
    if (!d) begin
      ncmp++; nerr++;
      $display("FAIL timeout_w%0d: got no done after %0d cycles", w, n);
    end
    lat = n;
    rq = (w == 7) ? int'(q_out7) : int'(q_out4);
    rn = (w == 7) ? int'(none7) : int'(none4);
`ifdef CYCLE_COUNT_EN
    if (d) chk("cycles", (w == 7) ? int'(cyc7) : int'(cyc4), n);
`endif
  endtask

  task automatic run(input int w, input int q, input bit dn,
                     input int lq, input int ln, output int lat);
    int rq, rn;
    go(w, q, dn);
    wait_done(w, 2, lat, rq, rn);
    if (lq >= 0) begin
      chk($sformatf("lit_q w%0d q%0d d%0d", w, q, dn), rq, lq);
      chk($sformatf("lit_none w%0d q%0d d%0d", w, q, dn), rn, ln);
    end
  endtask

  initial begin
    int lat, rq, rn;
    rst = 1'b1;
    dir = 1'b0;
    start7 = 1'b0; start4 = 1'b0;
    q7 = '0; q4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy7", int'(busy7), 0);
    chk("rst_done7", int'(done7), 0);
    chk("rst_q7", int'(q_out7), 0);
    chk("rst_none7", int'(none7), 0);
    chk("rst_busy4", int'(busy4), 0);
    chk("rst_done4", int'(done4), 0);
    chk("rst_q4", int'(q_out4), 0);
    chk("rst_none4", int'(none4), 0);
`ifdef CYCLE_COUNT_EN
    chk("rst_cyc7", int'(cyc7), 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    run(7, 90, 1'b1, 89, 0, lat);

    // Abort a search with reset five cycles after its start.
    go(7, 90, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy7), 0);
    chk("abort_done", int'(done7), 0);
    chk("abort_q", int'(q_out7), 0);
    chk("abort_none", int'(none7), 0);
    e7.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (100) begin @(posedge clk); #1; end
    chk("post_abort_busy", int'(busy7), 0);
    run(7, 90, 1'b0, 97, 0, lat);

    run(7, 127, 1'b1, 127, 0, lat);
    run(7, 2, 1'b1, 2, 0, lat);
    chk("lat_q2", lat, 3);
    run(7, 3, 1'b0, 3, 0, lat);
    chk("lat_q3", lat, 3);
    run(7, 0, 1'b0, 2, 0, lat);
    run(7, 1, 1'b0, 2, 0, lat);
    run(7, 126, 1'b0, 127, 0, lat);
    run(7, 25, 1'b0, 29, 0, lat);
    chk("lat_q25", lat, 46);

    run(4, 14, 1'b0, 0, 1, lat);
    run(4, 1, 1'b1, 0, 1, lat);
    run(4, 15, 1'b1, 13, 0, lat);

    // A start while busy must be ignored.
    go(7, 90, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    q7 = 7'd10;
    start7 = 1'b1;
    @(posedge clk); #1;
    start7 = 1'b0;
    chk("busy_during_ignored", int'(busy7), 1);
    wait_done(7, 6, lat, rq, rn);
    chk("ignored_q", rq, 97);

    // Start in the done cycle is accepted back-to-back.
    go(7, 90, 1'b0);
    wait_done(7, 2, lat, rq, rn);
    chk("b2b_first_q", rq, 97);
    go(7, 10, 1'b0);
    chk("b2b_busy", int'(busy7), 1);
    wait_done(7, 2, lat, rq, rn);
    chk("b2b_second_q", rq, 11);

    for (int q = 0; q < 128; q++) begin
      run(7, q, 1'b0, -1, 0, lat);
      run(7, q, 1'b1, -1, 0, lat);
    end
    for (int q = 0; q < 16; q++) begin
      run(4, q, 1'b0, -1, 0, lat);
      run(4, q, 1'b1, -1, 0, lat);
    end

    repeat (2) @(posedge clk);
    chk("pending7", e7.size(), 0);
    chk("pending4", e4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
